mult_pl_arbiter: RTL and testbench
==================================

# mult_pl_arbiter

Round-robin controller that shares one 3-stage pipelined 4x4 multiplier (`multiplier_PL_main`) among `NUM_REQ` requesters. It accepts at most one operand pair per cycle and drives the multiplier's `enable` and operand inputs. A tag pipeline matched to the multiplier latency returns each product with the requester ID. Response backpressure freezes the whole pipeline by deasserting `enable`.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, 2: requester ID width, equal to clog2(`NUM_REQ`).

Ports:
- `clock` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input `NUM_REQ`: per-requester operand valid.
- `req_a` input `NUM_REQ`*4: packed A operands; requester i uses bits [4i+3:4i].
- `req_b` input `NUM_REQ`*4: packed B operands, same packing.
- `req_ready` output `NUM_REQ`: one-hot grant; a transfer occurs when valid and ready are both high at a rising edge.
- `rsp_valid` output 1: product available.
- `rsp_id` output `ID_W`: requester that owns the product.
- `rsp_p` output 8: product, driven from `mul_p`.
- `rsp_ready` input 1: consumer accepts the response.
- `mul_enable` output 1: to multiplier `enable`.
- `mul_a` output 4: to multiplier `A`.
- `mul_b` output 4: to multiplier `B`.
- `mul_p` input 8: from multiplier `P`.
- `busy` output 1: any tag stage valid.

The multiplier shares `clock` and `rst` with this block.

## Operation
- `mul_enable` = !(`rsp_valid` && !`rsp_ready`). All pipeline advance is gated by this signal.
- Arbitration:
  - Round-robin pointer `last` holds the last granted ID.
  - Search order is `last`+1, `last`+2, … modulo `NUM_REQ`.
  - The first requester with `req_valid` set is granted.
- `req_ready`:
  - Combinational, one-hot to the winner, only when `mul_enable`=1.
  - All zero when stalled.
  - All zero when no requester is valid.
- `last` updates only on an accepted transfer.
- Operand mux:
  - `mul_a`/`mul_b` = the winner's operands when a grant is given.
  - Otherwise 4'h0, which produces a bubble.
- Tag pipeline:
  - 3 stages of {valid, id}.
  - Stage 0 captures {grant_any, winner_id} on each edge with `mul_enable`=1.
  - Stages 1–2 shift on the same condition.
  - Stage 2 gives `rsp_valid`/`rsp_id`.
- Stall (`mul_enable`=0):
  - Tags, `last`, and the multiplier registers all hold.
  - `rsp_p`/`rsp_id` stay stable while `rsp_valid` is high.
- Bubbles: an invalid stage-2 tag never asserts `rsp_valid`, whatever `mul_p` holds.
- Arithmetic: unsigned; 4x4 → 8 bits; no overflow possible (max 15*15=225).

## Timing
- Reset values:
  - `req_ready`=0.
  - `rsp_valid`=0, `rsp_id`=0, `busy`=0.
  - `mul_enable`=1.
  - `mul_a`=`mul_b`=0.
  - `last`=`NUM_REQ`-1, so requester 0 wins first.
- Latency:
  - Transfer accepted at edge E (cycle t).
  - `rsp_valid`=1 with the correct `rsp_p` in cycle t+3, after the third enabled edge, when no stall occurs.
  - Each stall cycle adds one cycle.
- Throughput: one transfer per cycle sustained while `rsp_ready`=1.
- Response handshake: the response retires at the edge where `rsp_valid`&&`rsp_ready`. The next stage-2 content appears in the following cycle.
- Simultaneous events:
  - A stalled cycle accepts no request even if `req_valid` is high.
  - Retire and accept in the same cycle is legal, because `mul_enable`=1 in that cycle.
- Reset mid-operation:
  - All in-flight tags are cleared immediately (asynchronous).
  - The in-flight products are discarded.
  - No response is issued for them.
  - `last` returns to `NUM_REQ`-1.
- `req_valid` deasserted without a grant: no state change. The requester may withdraw.

## Structure
- Package `mult_pl_pkg`: `MUL_W`=4, `PROD_W`=8, `MUL_LAT`=3, and the tag typedef {valid, id}.
- Tag pipeline depth is fixed to `MUL_LAT`.
- Sub-module `rr_arbiter`:
  - Inputs: `req`, `last`, `en`.
  - Outputs: one-hot `grant`, `grant_id`, `grant_any`.
  - Purely combinational.
  - `last` register and tag pipeline live in `mult_pl_arbiter`.

## Test plan
- Reset then single request: req0 A=3,B=5 at cycle 0 → `req_ready[0]`=1 in cycle 0; `rsp_valid`=1, `rsp_id`=0, `rsp_p`=8'd15 in cycle 3; `busy` low by cycle 4.
- All four requesters valid continuously with `rsp_ready`=1:
  - Grants go 0,1,2,3,0 on consecutive cycles.
  - Responses appear in the same ID order, one per cycle starting at cycle 3.
  - Products match operands (e.g. req2 A=15,B=15 → 225).
- Backpressure:
  - Hold `rsp_ready`=0 for 4 cycles while the first response is valid.
  - Expect `mul_enable`=0 and `req_ready`=0 throughout.
  - `rsp_p`/`rsp_id` stable; no response lost or duplicated after release.
- Sparse traffic: req1 at cycle 0 and req1 at cycle 2 → responses in cycles 3 and 5; `rsp_valid`=0 in cycle 4 (bubble).
- Fairness: req0 and req3 valid continuously → alternating grants 0,3,0,3; `last` wraps from 3 to 0.
- Asynchronous reset asserted mid-burst, with 3 products in flight:
  - `rsp_valid` drops immediately.
  - No stale responses after release.
  - The first grant after release goes to requester 0.

Source files
------------

// File: rtl/mult_pl_pkg.sv
// ---------------------------------------------------------------------------
// mult_pl_pkg
// Shared constants and types for the pipelined-multiplier arbiter.
//   MUL_W    : operand width of the shared multiplier
//   PROD_W   : product width of the shared multiplier
//   MUL_LAT  : register stages inside the multiplier (tag pipeline depth)
//   MAX_ID_W : widest requester ID carried in a tag (NUM_REQ up to 8)
//   tag_t    : {valid, id} travelling alongside each operand pair
// ---------------------------------------------------------------------------
package mult_pl_pkg;

   localparam int MUL_W    = 4;
   localparam int PROD_W   = 8;
   localparam int MUL_LAT  = 3;
   localparam int MAX_ID_W = 3;

   typedef struct packed {
      logic                valid;
      logic [MAX_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick among NUM_REQ requesters.
//   req       : per-requester valid
//   last      : ID granted most recently (search starts at last+1)
//   en        : when low, nothing is granted
//   grant     : one-hot winner
//   grant_id  : binary index of the winner
//   grant_any : a winner exists this cycle
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               grant_any
);

   // Walk the requesters starting just after the last winner; the first
   // valid one found wins and later candidates are ignored.
   always_comb begin
      int idx;
      grant     = '0;
      grant_id  = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (en && !grant_any && req[idx]) begin
            grant[idx] = 1'b1;
            grant_id   = ID_W'(idx);
            grant_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mult_pl_arbiter.sv
// ---------------------------------------------------------------------------
// mult_pl_arbiter
// Shares one 3-stage pipelined 4x4 multiplier among NUM_REQ requesters.
// A tag pipeline of matching depth returns each product with its owner ID.
// Response backpressure freezes everything by dropping mul_enable.
//   clock, rst          : clock, asynchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot grant)
//   req_a, req_b        : packed operands, requester i at [4i+3:4i]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id, rsp_p       : owner ID and product
//   mul_enable, mul_a, mul_b, mul_p : shared multiplier interface
//   busy                : any tag stage holds a valid entry
// ---------------------------------------------------------------------------
module mult_pl_arbiter
   import mult_pl_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                       clock,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*MUL_W-1:0]   req_a,
   input  logic [NUM_REQ*MUL_W-1:0]   req_b,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       rsp_valid,
   output logic [ID_W-1:0]            rsp_id,
   output logic [PROD_W-1:0]          rsp_p,
   input  logic                       rsp_ready,
   output logic                       mul_enable,
   output logic [MUL_W-1:0]           mul_a,
   output logic [MUL_W-1:0]           mul_b,
   input  logic [PROD_W-1:0]          mul_p,
   output logic                       busy
);

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_id;
   logic               grant_any;
   logic [ID_W-1:0]    last_q, last_d;
   tag_t               tag_q [MUL_LAT];
   tag_t               tag_d [MUL_LAT];

   // The pipeline may only advance when the stage-2 response is not stuck.
   assign mul_enable = !(tag_q[MUL_LAT-1].valid && !rsp_ready);

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .req       (req_valid),
      .last      (last_q),
      .en        (mul_enable),
      .grant     (grant),
      .grant_id  (grant_id),
      .grant_any (grant_any)
   );

   assign req_ready = grant;

   // Route the winner's operands to the multiplier; with no winner the
   // multiplier is fed zeros and the matching tag is a bubble.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      if (grant_any) begin
         mul_a = req_a[int'(grant_id)*MUL_W +: MUL_W];
         mul_b = req_b[int'(grant_id)*MUL_W +: MUL_W];
      end
   end

   // Next-state for the tag pipeline and the round-robin pointer. Both hold
   // while stalled so they stay aligned with the frozen multiplier stages.
   // A grant always implies a transfer, since grants need req_valid.
   always_comb begin
      last_d = last_q;
      tag_d  = tag_q;
      if (mul_enable) begin
         tag_d[0].valid = grant_any;
         tag_d[0].id    = MAX_ID_W'(grant_id);
         for (int i = 1; i < MUL_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
         end
         if (grant_any) begin
            last_d = grant_id;
         end
      end
   end

   // State registers; reset points the pointer at the highest ID so that
   // requester 0 is searched first.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         last_q <= ID_W'(NUM_REQ - 1);
         for (int i = 0; i < MUL_LAT; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         last_q <= last_d;
         for (int i = 0; i < MUL_LAT; i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

   // Response comes straight from the last tag stage and the multiplier.
   assign rsp_valid = tag_q[MUL_LAT-1].valid;
   assign rsp_id    = tag_q[MUL_LAT-1].id[ID_W-1:0];
   assign rsp_p     = mul_p;

   // Busy whenever any stage carries a live operand.
   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < MUL_LAT; i++) begin
         busy = busy | tag_q[i].valid;
      end
   end

endmodule

// File: tb/tb_mult_pl_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mult_pl_arbiter
// Directed bench for mult_pl_arbiter with a behavioural 3-stage multiplier.
// Stimulus pushes hand-computed {id, product} entries into a queue; a
// monitor pops one whenever a response handshake happens.
// ---------------------------------------------------------------------------
module tb_mult_pl_arbiter;

   logic        clock;
   logic        rst;
   logic [3:0]  req_valid;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_p;
   logic        rsp_ready;
   logic        mul_enable;
   logic [3:0]  mul_a;
   logic [3:0]  mul_b;
   logic [7:0]  mul_p;
   logic        busy;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] p;
   } exp_t;

   exp_t expQ [$];
   exp_t monE;
   int   vectors;
   int   miscompares;

   logic [7:0] s0, s1, s2;

   mult_pl_arbiter #(
      .NUM_REQ (4),
      .ID_W    (2)
   ) dut (
      .clock      (clock),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_p      (rsp_p),
      .rsp_ready  (rsp_ready),
      .mul_enable (mul_enable),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_p      (mul_p),
      .busy       (busy)
   );

   // Free-running 10ns clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Stand-in for the shared 3-stage multiplier: freezes with enable low,
   // clears on reset.
   always @(posedge clock or posedge rst) begin
      if (rst) begin
         s0 <= '0;
         s1 <= '0;
         s2 <= '0;
      end else if (mul_enable) begin
         s0 <= 8'(mul_a) * 8'(mul_b);
         s1 <= s0;
         s2 <= s1;
      end
   end
   assign mul_p = s2;

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Response monitor: every accepted response must match the queue head.
   always @(negedge clock) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("rsp_unexpected", 16'd1, 16'd0);
         end else begin
            monE = expQ.pop_front();
            checkOutput("rsp_id", 16'(rsp_id), 16'(monE.id));
            checkOutput("rsp_p", 16'(rsp_p), 16'(monE.p));
         end
      end
   end

   // One cycle: drive inputs at cycle start, check mid-cycle, advance to the
   // next cycle start. Pushes the expected response if a grant is expected.
   task automatic applyStimulus(input logic [3:0] valid, input logic [15:0] a, input logic [15:0] b,
                                input logic rdy, input logic [3:0] expReady, input logic [7:0] expP,
                                input logic expRspValid, input logic expEnable);
      int   idx;
      exp_t e;
      req_valid = valid;
      req_a     = a;
      req_b     = b;
      rsp_ready = rdy;
      idx       = -1;
      for (int i = 0; i < 4; i++) begin
         if (expReady[i]) idx = i;
      end
      if (idx >= 0) begin
         e.id = 2'(idx);
         e.p  = expP;
         expQ.push_back(e);
      end
      @(negedge clock);
      checkOutput("req_ready", 16'(req_ready), 16'(expReady));
      checkOutput("rsp_valid", 16'(rsp_valid), 16'(expRspValid));
      checkOutput("mul_enable", 16'(mul_enable), 16'(expEnable));
      if (idx >= 0) begin
         checkOutput("mul_a", 16'(mul_a), 16'(a[idx*4 +: 4]));
         checkOutput("mul_b", 16'(mul_b), 16'(b[idx*4 +: 4]));
      end else begin
         checkOutput("mul_a_idle", 16'(mul_a), 16'd0);
         checkOutput("mul_b_idle", 16'(mul_b), 16'd0);
      end
      @(posedge clock);
      #1;
   endtask

   // Stalled cycle: all requesters ask, nothing may be granted, response holds.
   task automatic stallCycle(input logic [1:0] expId, input logic [7:0] expP);
      req_valid = 4'b1111;
      req_a     = 16'hFFFF;
      req_b     = 16'hFFFF;
      rsp_ready = 1'b0;
      @(negedge clock);
      checkOutput("stall_enable", 16'(mul_enable), 16'd0);
      checkOutput("stall_ready", 16'(req_ready), 16'd0);
      checkOutput("stall_valid", 16'(rsp_valid), 16'd1);
      checkOutput("stall_id", 16'(rsp_id), 16'(expId));
      checkOutput("stall_p", 16'(rsp_p), 16'(expP));
      @(posedge clock);
      #1;
   endtask

   // Idle cycle that also expects the pipeline to be drained.
   task automatic checkIdle();
      req_valid = '0;
      rsp_ready = 1'b1;
      @(negedge clock);
      checkOutput("idle_busy", 16'(busy), 16'd0);
      checkOutput("idle_rsp_valid", 16'(rsp_valid), 16'd0);
      @(posedge clock);
      #1;
   endtask

   task automatic doReset();
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      rst       = 1'b1;
      expQ.delete();
      repeat (2) @(posedge clock);
      #1;
      rst = 1'b0;
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      req_valid   = '0;
      req_a       = '0;
      req_b       = '0;
      rsp_ready   = 1'b1;

      // Reset values.
      @(negedge clock);
      checkOutput("rst_req_ready", 16'(req_ready), 16'd0);
      checkOutput("rst_rsp_valid", 16'(rsp_valid), 16'd0);
      checkOutput("rst_rsp_id", 16'(rsp_id), 16'd0);
      checkOutput("rst_busy", 16'(busy), 16'd0);
      checkOutput("rst_mul_enable", 16'(mul_enable), 16'd1);
      checkOutput("rst_mul_a", 16'(mul_a), 16'd0);
      checkOutput("rst_mul_b", 16'(mul_b), 16'd0);

      // Single request, 3*5, latency 3.
      doReset();
      applyStimulus(4'b0001, 16'h0003, 16'h0005, 1'b1, 4'b0001, 8'd15, 1'b0, 1'b1);
      applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 8'd0, 1'b0, 1'b1);
      applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 8'd0, 1'b0, 1'b1);
      applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 8'd0, 1'b1, 1'b1);
      checkIdle();

      // All four requesters continuously: grants 0,1,2,3,0.
      doReset();
      applyStimulus(4'b1111, 16'h9F41, 16'h3F72, 1'b1, 4'b0001, 8'd2,   1'b0, 1'b1);
      applyStimulus(4'b1111, 16'h9F41, 16'h3F72, 1'b1, 4'b0010, 8'd28,  1'b0, 1'b1);
      applyStimulus(4'b1111, 16'h9F41, 16'h3F72, 1'b1, 4'b0100, 8'd225, 1'b0, 1'b1);
      applyStimulus(4'b1111, 16'h9F41, 16'h3F72, 1'b1, 4'b1000, 8'd27,  1'b1, 1'b1);
      applyStimulus(4'b1111, 16'h9F41, 16'h3F72, 1'b1, 4'b0001, 8'd2,   1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 8'd0, 1'b1, 1'b1);
      end
      checkIdle();

      // Backpressure for 4 cycles on the first response.
      doReset();
      applyStimulus(4'b0001, 16'h0002, 16'h0006, 1'b1, 4'b0001, 8'd12, 1'b0, 1'b1);
      applyStimulus(4'b0010, 16'h0030, 16'h0030, 1'b1, 4'b0010, 8'd9,  1'b0, 1'b1);
      applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 8'd0,  1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         stallCycle(2'd0, 8'd12);
      end
      applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 8'd0, 1'b1, 1'b1);
      applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 8'd0, 1'b1, 1'b1);
      checkIdle();

      // Sparse traffic: bubble between two responses.
      doReset();
      applyStimulus(4'b0010, 16'h0050, 16'h0070, 1'b1, 4'b0010, 8'd35, 1'b0, 1'b1);
      applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 8'd0,  1'b0, 1'b1);
      applyStimulus(4'b0010, 16'h0060, 16'h0060, 1'b1, 4'b0010, 8'd36, 1'b0, 1'b1);
      applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 8'd0,  1'b1, 1'b1);
      applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 8'd0,  1'b0, 1'b1);
      applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 8'd0,  1'b1, 1'b1);
      checkIdle();

      // Fairness between requesters 0 and 3, pointer wraps 3 -> 0.
      doReset();
      applyStimulus(4'b1001, 16'h9002, 16'h8003, 1'b1, 4'b0001, 8'd6,  1'b0, 1'b1);
      applyStimulus(4'b1001, 16'h9002, 16'h8003, 1'b1, 4'b1000, 8'd72, 1'b0, 1'b1);
      applyStimulus(4'b1001, 16'h9002, 16'h8003, 1'b1, 4'b0001, 8'd6,  1'b0, 1'b1);
      applyStimulus(4'b1001, 16'h9002, 16'h8003, 1'b1, 4'b1000, 8'd72, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 8'd0, 1'b1, 1'b1);
      end
      checkIdle();

      // Asynchronous reset with three products in flight.
      doReset();
      applyStimulus(4'b1111, 16'h4321, 16'h5555, 1'b1, 4'b0001, 8'd5,  1'b0, 1'b1);
      applyStimulus(4'b1111, 16'h4321, 16'h5555, 1'b1, 4'b0010, 8'd10, 1'b0, 1'b1);
      applyStimulus(4'b1111, 16'h4321, 16'h5555, 1'b1, 4'b0100, 8'd15, 1'b0, 1'b1);
      req_valid = '0;
      checkOutput("pre_rst_rsp_valid", 16'(rsp_valid), 16'd1);
      checkOutput("pre_rst_busy", 16'(busy), 16'd1);
      rst = 1'b1;
      #1;
      checkOutput("async_rst_rsp_valid", 16'(rsp_valid), 16'd0);
      checkOutput("async_rst_busy", 16'(busy), 16'd0);
      expQ.delete();
      @(posedge clock);
      #1;
      rst = 1'b0;
      applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 8'd0, 1'b0, 1'b1);
      applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 8'd0, 1'b0, 1'b1);
      applyStimulus(4'b1111, 16'h4327, 16'h5553, 1'b1, 4'b0001, 8'd21, 1'b0, 1'b1);
      applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 8'd0, 1'b0, 1'b1);
      applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 8'd0, 1'b0, 1'b1);
      applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 8'd0, 1'b1, 1'b1);
      checkIdle();

      checkOutput("queue_empty", 16'(expQ.size()), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
